// File: rtl/vending_controller.sv
// Coin-operated vending controller: accumulates credit, sells one of four products, returns change.
// Latency: every response is registered and appears in the cycle after the input edge that triggered it.
// Backpressure: dispense_valid/dispense_id hold until dispense_ready; coins are refused while busy.
//
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   coin_valid, coin_val      - coin strobe; code 00=5, 01=10, 10=25, 11=invalid
//   sel_valid, sel            - product selection strobe and index 0..3
//   cancel                    - return all credit as change
//   dispense_ready            - dispense mechanism accepts the pending request
//   credit                    - current credit in cents
//   coin_reject               - one-cycle pulse, coin refused
//   err_insufficient          - one-cycle pulse, selection refused
//   dispense_valid/_id        - dispense request and product index
//   change_valid/change_amt   - one-cycle change pulse and amount (0 otherwise)
//   busy                      - high while dispensing or returning change
module vending_controller #(
    parameter int PRICE0     = 25,
    parameter int PRICE1     = 50,
    parameter int PRICE2     = 75,
    parameter int PRICE3     = 100,
    parameter int MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       dispense_ready,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       err_insufficient,
    output logic       dispense_valid,
    output logic [1:0] dispense_id,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [7:0] P0    = 8'(PRICE0);
    localparam logic [7:0] P1    = 8'(PRICE1);
    localparam logic [7:0] P2    = 8'(PRICE2);
    localparam logic [7:0] P3    = 8'(PRICE3);
    localparam logic [8:0] MAX_C = 9'(MAX_CREDIT);

    state_t     state, state_nx;
    logic [7:0] credit_nx;
    logic       coin_reject_nx;
    logic       err_nx;
    logic       dispense_valid_nx;
    logic [1:0] dispense_id_nx;
    logic       change_valid_nx;
    logic [7:0] change_amt_nx;
    logic       busy_nx;

    logic [7:0] coin_cents;
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic [7:0] price_sel;

    always_comb begin
        case (coin_val)
            2'b00:   coin_cents = 8'd5;
            2'b01:   coin_cents = 8'd10;
            2'b10:   coin_cents = 8'd25;
            default: coin_cents = 8'd0;
        endcase
        case (sel)
            2'd0:    price_sel = P0;
            2'd1:    price_sel = P1;
            2'd2:    price_sel = P2;
            default: price_sel = P3;
        endcase
        // Sum is one bit wider so an overflow past 255 cannot wrap into an accepted value.
        coin_sum  = {1'b0, credit} + {1'b0, coin_cents};
        coin_fits = (coin_val != 2'b11) && (coin_sum <= MAX_C);
    end

    always_comb begin
        state_nx          = state;
        credit_nx         = credit;
        coin_reject_nx    = 1'b0;
        err_nx            = 1'b0;
        dispense_valid_nx = dispense_valid;
        dispense_id_nx    = dispense_id;
        change_valid_nx   = 1'b0;
        change_amt_nx     = 8'd0;

        case (state)
            S_IDLE, S_CREDIT: begin
                // Priority cancel > sel > coin; a coin arriving with a winning event is refused.
                // Cancel is meaningless in IDLE (no credit), so there it does not take priority.
                if (cancel && state == S_CREDIT) begin
                    coin_reject_nx  = coin_valid;
                    change_valid_nx = 1'b1;
                    change_amt_nx   = credit;
                    credit_nx       = 8'd0;
                    state_nx        = S_CHANGE;
                end else if (sel_valid) begin
                    coin_reject_nx = coin_valid;
                    if (state == S_CREDIT && credit >= price_sel) begin
                        credit_nx         = credit - price_sel;
                        dispense_id_nx    = sel;
                        dispense_valid_nx = 1'b1;
                        state_nx          = S_DISPENSE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_nx = coin_sum[7:0];
                        state_nx  = S_CREDIT;
                    end else begin
                        coin_reject_nx = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_nx = coin_valid;
                if (dispense_ready) begin
                    dispense_valid_nx = 1'b0;
                    if (credit != 8'd0) begin
                        // Change pulse is raised on entry so it is visible for the single CHANGE cycle.
                        change_valid_nx = 1'b1;
                        change_amt_nx   = credit;
                        credit_nx       = 8'd0;
                        state_nx        = S_CHANGE;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                coin_reject_nx = coin_valid;
                state_nx       = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx == S_DISPENSE) || (state_nx == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            credit           <= 8'd0;
            coin_reject      <= 1'b0;
            err_insufficient <= 1'b0;
            dispense_valid   <= 1'b0;
            dispense_id      <= 2'd0;
            change_valid     <= 1'b0;
            change_amt       <= 8'd0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nx;
            credit           <= credit_nx;
            coin_reject      <= coin_reject_nx;
            err_insufficient <= err_nx;
            dispense_valid   <= dispense_valid_nx;
            dispense_id      <= dispense_id_nx;
            change_valid     <= change_valid_nx;
            change_amt       <= change_amt_nx;
            busy             <= busy_nx;
        end
    end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL have parameter PRICE0, default 25, price of product 0 in cents.
REQ-002 SHALL have parameter PRICE1, default 50, price of product 1 in cents.
REQ-003 SHALL have parameter PRICE2, default 75, price of product 2 in cents.
REQ-004 SHALL have parameter PRICE3, default 100, price of product 3 in cents.
REQ-005 SHALL have parameter MAX_CREDIT, default 200, upper limit on accumulated credit in cents (at most 255).
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port coin_valid  input  1  coin present this cycle.
REQ-009 SHALL have port coin_val  input  2  coin code: 00=5, 01=10, 10=25, 11=invalid.
REQ-010 SHALL have port sel_valid  input  1  product selection this cycle.
REQ-011 SHALL have port sel  input  2  selected product index 0..3.
REQ-012 SHALL have port cancel  input  1  return-credit request.
REQ-013 SHALL have port dispense_ready  input  1  dispense mechanism accepts the request.
REQ-014 SHALL have port credit  output  8  current credit in cents.
REQ-015 SHALL have port coin_reject  output  1  one-cycle pulse; the coin was refused.
REQ-016 SHALL have port err_insufficient  output  1  one-cycle pulse; the selection was refused.
REQ-017 SHALL have port dispense_valid  output  1  dispense request.
REQ-018 SHALL have port dispense_id  output  2  product being dispensed.
REQ-019 SHALL have port change_valid  output  1  one-cycle pulse; change is being returned.
REQ-020 SHALL have port change_amt  output  8  change value in cents; valid while change_valid=1.
REQ-021 SHALL have port busy  output  1  high in DISPENSE and CHANGE.

Function
REQ-022 SHALL implement states IDLE (credit=0), CREDIT (credit>0), DISPENSE and CHANGE.
REQ-023 SHALL register all outputs; each response SHALL appear in the cycle after the triggering input edge.
REQ-024 SHALL, in IDLE or CREDIT, accept a coin when coin_valid=1, coin_val!=11 and credit+value<=MAX_CREDIT; it SHALL add the value to credit and move to CREDIT.
REQ-025 SHALL otherwise reject the coin: pulse coin_reject for 1 cycle and leave credit unchanged.
REQ-026 SHALL reject all coins in DISPENSE and CHANGE with a coin_reject pulse.
REQ-027 SHALL, on sel_valid in CREDIT with credit>=PRICE[sel], set credit to credit-PRICE[sel], latch dispense_id=sel, assert dispense_valid and enter DISPENSE.
REQ-028 SHALL, on sel_valid in IDLE, or in CREDIT with credit<PRICE[sel], pulse err_insufficient for 1 cycle and leave state and credit unchanged.
REQ-029 SHALL hold dispense_valid and dispense_id stable until a cycle in which dispense_ready=1; the transfer SHALL complete in that cycle.
REQ-030 SHALL, after the transfer, deassert dispense_valid and enter CHANGE if credit>0, otherwise IDLE.
REQ-031 SHALL, in CHANGE, pulse change_valid for exactly 1 cycle with change_amt=credit, clear credit to 0 and enter IDLE.
REQ-032 SHALL move from CREDIT to CHANGE on cancel.
REQ-033 SHALL ignore cancel in IDLE, DISPENSE and CHANGE.
REQ-034 SHALL resolve simultaneous events in priority order cancel > sel_valid > coin_valid.
REQ-035 SHALL reject a coin that loses priority, with a coin_reject pulse.
REQ-036 SHALL ignore a selection that loses priority, with no err pulse.
REQ-037 SHALL ignore dispense_ready outside DISPENSE.
REQ-038 SHALL drive change_amt=0 when change_valid=0.
REQ-039 SHALL assert exactly one of dispense_valid or change_valid at a time, never both.

Reset
REQ-040 SHALL, when rst=1 at a rising clk edge, enter IDLE from any state, including mid-DISPENSE.
REQ-041 SHALL, on reset, drive credit=0, coin_reject=0, err_insufficient=0, dispense_valid=0, dispense_id=0, change_valid=0, change_amt=0 and busy=0.
REQ-042 SHALL discard any credit present at reset without returning change.
REQ-043 SHALL keep rst dominant over all other inputs in the same cycle.

Verification
REQ-044 Bench SHALL apply coins 25,25 then sel=1 with dispense_ready=1 -> credit 25,50,0; dispense_valid 1 cycle with id=1; no change_valid.
REQ-045 Bench SHALL apply coins 25,25,25,25 then sel=0, holding dispense_ready=0 for 3 cycles -> dispense_valid held 4 cycles with id=0; then change_valid with change_amt=75; credit=0; state IDLE.
REQ-046 Bench SHALL apply credit 200 then coin 5, then coin code 11 -> coin_reject pulse for each; credit stays 200.
REQ-047 Bench SHALL apply coin 10 then sel=2, then cancel -> err_insufficient pulse; credit 10; then change_valid with change_amt=10.
REQ-048 Bench SHALL apply coin_valid, sel_valid and cancel in the same cycle at credit 50 -> coin_reject pulse; change_amt=50; no dispense.
REQ-049 Bench SHALL assert rst during DISPENSE with credit 25 -> next cycle dispense_valid=0, credit=0, busy=0; no change_valid.
